// File: rtl/mod_add_serial_pkg.sv
// rtl/mod_add_serial_pkg.sv - shared field-arithmetic constants, state encoding and limb-count helper
package mod_add_serial_pkg;

  localparam int FA_WIDTH = 255;
  localparam int FA_LIMB  = 64;

  // ceil((width+1)/limb): always leaves at least one guard bit above the operand
  function automatic int limb_count(input int width, input int limb);
    return (width + limb) / limb;
  endfunction

  localparam int FA_NUM_LIMBS = limb_count(FA_WIDTH, FA_LIMB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_add_limb.sv
// rtl/mod_add_limb.sv - one limb of the parallel add and add-minus-modulus chains
module mod_add_limb #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] a_k,
  input  logic [LIMB-1:0] b_k,
  input  logic [LIMB-1:0] q_k,
  input  logic            cin,
  input  logic            bin,
  output logic [LIMB-1:0] s_k,
  output logic [LIMB-1:0] d_k,
  output logic            cout,
  output logic            bout
);

  logic [LIMB:0] s_full;
  logic [LIMB:0] d_full;

  assign s_full = {1'b0, a_k} + {1'b0, b_k} + {{LIMB{1'b0}}, cin};
  // the borrow chain subtracts Q from the sum limb just produced, not from A+B as a whole
  assign d_full = {1'b0, s_full[LIMB-1:0]} - {1'b0, q_k} - {{LIMB{1'b0}}, bin};

  assign s_k  = s_full[LIMB-1:0];
  assign cout = s_full[LIMB];
  assign d_k  = d_full[LIMB-1:0];
  assign bout = d_full[LIMB];

endmodule

// File: rtl/mod_add_serial.sv
// rtl/mod_add_serial.sv - limb-serial (A + B) mod Q with valid/ready handshakes
module mod_add_serial
  import mod_add_serial_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH,
  parameter int LIMB  = FA_LIMB
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_q,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum
);

  localparam int NUM_LIMBS = limb_count(WIDTH, LIMB);
  localparam int PW        = NUM_LIMBS * LIMB;
  localparam int CW        = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            carry_q, borrow_q;
  logic [PW-1:0]   a_sr, b_sr, q_sr, sum_sr, diff_sr;
  logic [WIDTH-1:0] sum_q;

  logic [LIMB-1:0] s_k, d_k;
  logic            cout, bout;
  logic            accept, last_limb;
  logic [PW-1:0]   sum_next, diff_next;
  logic            unused_bits;

  mod_add_limb #(.LIMB(LIMB)) u_limb (
    .a_k  (a_sr[LIMB-1:0]),
    .b_k  (b_sr[LIMB-1:0]),
    .q_k  (q_sr[LIMB-1:0]),
    .cin  (carry_q),
    .bin  (borrow_q),
    .s_k  (s_k),
    .d_k  (d_k),
    .cout (cout),
    .bout (bout)
  );

  assign accept    = (state_q == IDLE) && i_in_valid;
  assign last_limb = (cnt_q == CW'(NUM_LIMBS - 1));

  // result registers fill from the top so limb k lands in slice k after the last step
  assign sum_next  = {s_k, sum_sr[PW-1:LIMB]};
  assign diff_next = {d_k, diff_sr[PW-1:LIMB]};

  assign o_in_ready  = (state_q == IDLE);
  assign o_out_valid = (state_q == DONE);
  assign o_sum       = sum_q;

  assign unused_bits = ^{sum_sr[LIMB-1:0], diff_sr[LIMB-1:0],
                         sum_next[PW-1:WIDTH], diff_next[PW-1:WIDTH]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_limb) state_d = DONE;
      DONE:    if (i_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      q_sr     <= '0;
      sum_sr   <= '0;
      diff_sr  <= '0;
      sum_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sr     <= {{(PW-WIDTH){1'b0}}, i_a};
        b_sr     <= {{(PW-WIDTH){1'b0}}, i_b};
        q_sr     <= {{(PW-WIDTH){1'b0}}, i_q};
        cnt_q    <= '0;
        carry_q  <= 1'b0;
        borrow_q <= 1'b0;
      end else if (state_q == CALC) begin
        a_sr     <= a_sr >> LIMB;
        b_sr     <= b_sr >> LIMB;
        q_sr     <= q_sr >> LIMB;
        sum_sr   <= sum_next;
        diff_sr  <= diff_next;
        carry_q  <= cout;
        borrow_q <= bout;
        cnt_q    <= cnt_q + 1'b1;
        // no final borrow means A+B >= Q, so the reduced value is taken
        if (last_limb)
          sum_q <= bout ? sum_next[WIDTH-1:0] : diff_next[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mod_add_serial.sv
// tb/tb_mod_add_serial.sv - randomized and directed self-checking bench for mod_add_serial
module tb_mod_add_serial;

  localparam int W = 255;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic [W-1:0] i_q = '0;
  logic         o_out_valid;
  logic         i_out_ready = 1'b0;
  logic [W-1:0] o_sum;

  int n_checks = 0;
  int n_errors = 0;

  mod_add_serial dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_q         (i_q),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_sum       (o_sum)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mod_add(input logic [W-1:0] a, b, q);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  // Issues one operation, optionally stalls the output for `hold` cycles while
  // offering a competing input, then drains the result.
  task automatic run_op(input string tag, input logic [W-1:0] a, b, q, exp, input int hold);
    int lat;
    @(negedge i_clk);
    i_a = a; i_b = b; i_q = q; i_in_valid = 1'b1;
    check({tag, ".in_ready"}, {{W{1'b0}}, o_in_ready}, 1);
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    i_a = ~a; i_b = ~b; i_q = ~q;
    lat = 0;
    while (!o_out_valid && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    check({tag, ".latency"}, (W+1)'(lat), 4);
    check({tag, ".sum"}, {1'b0, o_sum}, {1'b0, exp});
    for (int h = 0; h < hold; h++) begin
      i_in_valid = 1'b1;
      @(posedge i_clk); #1;
      check({tag, ".hold_valid"}, {{W{1'b0}}, o_out_valid}, 1);
      check({tag, ".hold_sum"}, {1'b0, o_sum}, {1'b0, exp});
      check({tag, ".hold_in_ready"}, {{W{1'b0}}, o_in_ready}, 0);
    end
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_out_ready = 1'b0;
    i_in_valid = 1'b0;
    if (hold > 0) begin
      check({tag, ".drain_valid"}, {{W{1'b0}}, o_out_valid}, 0);
      check({tag, ".drain_in_ready"}, {{W{1'b0}}, o_in_ready}, 1);
      @(posedge i_clk); #1;
      check({tag, ".no_reaccept"}, {{W{1'b0}}, o_in_ready}, 1);
    end
  endtask

  logic [W-1:0] qp, one, a, b, q;

  initial begin
    qp  = '1;
    qp  = qp - 255'd18;
    one = 255'd1;

    #12;
    check("rst.in_ready", {{W{1'b0}}, o_in_ready}, 1);
    check("rst.out_valid", {{W{1'b0}}, o_out_valid}, 0);
    check("rst.sum", {1'b0, o_sum}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op("small", 255'd5, 255'd7, qp, 255'd12, 0);
    run_op("wrap", qp - 255'd1, 255'd1, qp, 255'd0, 0);
    run_op("max", qp - 255'd1, qp - 255'd1, qp, qp - 255'd2, 0);
    run_op("limb01", (one << 64) - one, one, qp, one << 64, 0);
    run_op("limb12", (one << 128) - one, one, qp, one << 128, 0);
    run_op("backpressure", 255'd5, 255'd7, qp, 255'd12, 3);

    // reset during the second CALC cycle discards the operation
    @(negedge i_clk);
    i_a = 255'd5; i_b = 255'd7; i_q = qp; i_in_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst.out_valid", {{W{1'b0}}, o_out_valid}, 0);
    check("midrst.in_ready", {{W{1'b0}}, o_in_ready}, 1);
    check("midrst.sum", {1'b0, o_sum}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op("after_rst", 255'd3, 255'd4, qp, 255'd7, 0);

    for (int n = 0; n < 24; n++) begin
      q = rand_wide();
      if (n % 3 == 0) q[W-1] = 1'b1;
      if (q == '0) q = qp;
      a = rand_wide() % q;
      b = rand_wide() % q;
      if (n % 4 == 1) b = q - a - 255'(n % 2);
      if (a >= q) a = '0;
      if (b >= q) b = '0;
      run_op($sformatf("rand%0d", n), a, b, q, ref_mod_add(a, b, q), n % 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
